// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-lane write enables and one read port.
// Optional per-lane even parity is compiled in when RAM_SDP_BE_PARITY_EN is defined;
// otherwise par_err is tied low and the port list is unchanged.
// After reset an optional clear sequencer zeroes every word, one per cycle, while busy=1.
module ram_sdp_be #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        busy,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W/BYTE_W-1:0]    wr_be,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_valid,
  output logic                        par_err
);

  localparam int unsigned NB    = DATA_W / BYTE_W;
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;

  logic              clr_we;
  logic              wr_accept;
  logic              rd_accept;
  logic              rdw_hit;

  logic [DATA_W-1:0] mem_q [Depth];

  logic [DATA_W-1:0] rd_word;
  logic              rd_perr;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_perr_q, s1_perr_d;

  // Port requests are dropped while clearing and in the reset cycle itself.
  assign clr_we    = (state_q == StClear) && !reset;
  assign wr_accept = wr_en && !busy_q && !reset;
  assign rd_accept = rd_en && !busy_q && !reset;
  assign rdw_hit   = wr_accept && (wr_addr == rd_addr);
  assign busy      = busy_q;

  // Clear sequencer next state: walk every address once, then go ready.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (reset) begin
      state_d   = (CLEAR_ON_RESET != 0) ? StClear : StReady;
      clr_cnt_d = '0;
    end else if (state_q == StClear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == {ADDR_W{1'b1}}) begin
        state_d = StReady;
      end
    end
    busy_d = (state_d == StClear);
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_cnt_q <= clr_cnt_d;
    busy_q    <= busy_d;
  end

  // Data array: clear writes whole words, port writes only enabled lanes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_accept) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Read word, with write-first lane merge when configured.
  always_comb begin
    rd_word = mem_q[rd_addr];
    if ((RDW_MODE != 0) && rdw_hit) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

`ifdef RAM_SDP_BE_PARITY_EN
  logic [NB-1:0] par_q [Depth];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_par_stored;
  logic [NB-1:0] rd_par_calc;

  function automatic logic [NB-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [NB-1:0] p;
    for (int unsigned i = 0; i < NB; i++) begin
      p[i] = ^d[i*BYTE_W +: BYTE_W];
    end
    return p;
  endfunction

  assign wr_par = lane_par(wr_data);

  // Parity array tracks the data array lane by lane; zero words have zero even parity.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_q[clr_cnt_q] <= '0;
    end else if (wr_accept) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          par_q[wr_addr][i] <= wr_par[i];
        end
      end
    end
  end

  // Check the returned word against its stored (or merged) parity.
  always_comb begin
    rd_par_stored = par_q[rd_addr];
    if ((RDW_MODE != 0) && rdw_hit) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_par_stored[i] = wr_par[i];
        end
      end
    end
    rd_par_calc = lane_par(rd_word);
    rd_perr     = |(rd_par_stored ^ rd_par_calc);
  end
`else
  assign rd_perr = 1'b0;
`endif

  // First read stage: capture on accept, hold data otherwise.
  always_comb begin
    s1_valid_d = rd_accept;
    s1_data_d  = rd_accept ? rd_word : s1_data_q;
    s1_perr_d  = rd_accept && rd_perr;
    if (reset) begin
      s1_valid_d = 1'b0;
      s1_data_d  = '0;
      s1_perr_d  = 1'b0;
    end
  end

  // First read stage registers.
  always_ff @(posedge clk) begin
    s1_valid_q <= s1_valid_d;
    s1_data_q  <= s1_data_d;
    s1_perr_q  <= s1_perr_d;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_perr_q, s2_perr_d;

    // Extra output stage; data only moves when a valid read arrives.
    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
      s2_perr_d  = s1_perr_q;
      if (reset) begin
        s2_valid_d = 1'b0;
        s2_data_d  = '0;
        s2_perr_d  = 1'b0;
      end
    end

    // Second read stage registers.
    always_ff @(posedge clk) begin
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_perr_q  <= s2_perr_d;
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
    assign par_err  = s2_perr_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
    assign par_err  = s1_perr_q;
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: two instances share stimulus, one with RD_LAT=1/old-data and one with
// RD_LAT=2/write-first, both 16 words deep with clear-on-reset. A word-array model predicts
// every output each cycle; directed scenarios are followed by random traffic.
module tb_ram_sdp_be;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned NBL   = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [NBL-1:0] wr_be;
  logic [DW-1:0] wr_data;

  logic          busy0, busy1, v0, v1, p0, p1;
  logic [DW-1:0] d0, d1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_bad [DEPTH];
  int            clear_left;
  logic          e_busy;
  logic          e0_v, e0_p, s1_v, s1_p, e1_v, e1_p;
  logic [DW-1:0] e0_d, s1_d, e1_d;

  always #5 clk = ~clk;

  ram_sdp_be #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .RD_LAT(1), .RDW_MODE(0),
               .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .reset(reset), .busy(busy0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0),
    .par_err(p0)
  );

  ram_sdp_be #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(8), .RD_LAT(2), .RDW_MODE(1),
               .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .reset(reset), .busy(busy1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1),
    .par_err(p1)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [NBL-1:0] be,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [NBL-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NBL; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // One clock: advance the model with the inputs applied at this edge, then compare outputs.
  task automatic tick();
    logic busy_now, acc_r, acc_w, hit;
    @(posedge clk);
    // Latency-2 output stage takes what the first stage held before this edge.
    if (s1_v) e1_d = s1_d;
    e1_v = s1_v;
    e1_p = s1_v & s1_p;
    if (reset) begin
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_bad[i] = 1'b0; end
      e0_v = 0; e0_d = '0; e0_p = 0;
      s1_v = 0; s1_d = '0; s1_p = 0;
      e1_v = 0; e1_d = '0; e1_p = 0;
    end else begin
      busy_now = (clear_left > 0);
      if (busy_now) clear_left--;
      acc_r = rd_en && !busy_now;
      acc_w = wr_en && !busy_now;
      hit   = acc_w && (wr_addr == rd_addr);
      if (acc_r) begin
        e0_v = 1; e0_d = m_mem[rd_addr]; e0_p = m_bad[rd_addr];
        s1_v = 1;
        s1_d = hit ? merge(m_mem[rd_addr], wr_data, wr_be) : m_mem[rd_addr];
        s1_p = m_bad[rd_addr] && !(hit && wr_be[1]);
      end else begin
        e0_v = 0; e0_p = 0; s1_v = 0; s1_p = 0;
      end
      if (acc_w) begin
        m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
        if (wr_be[1]) m_bad[wr_addr] = 1'b0;
      end
    end
    e_busy = (clear_left > 0);
    #1;
    check_eq("busy0", {31'd0, busy0}, {31'd0, e_busy});
    check_eq("busy1", {31'd0, busy1}, {31'd0, e_busy});
    check_eq("rd_valid0", {31'd0, v0}, {31'd0, e0_v});
    check_eq("rd_valid1", {31'd0, v1}, {31'd0, e1_v});
    check_eq("rd_data0", d0, e0_d);
    check_eq("rd_data1", d1, e1_d);
    check_eq("par_err0", {31'd0, p0}, {31'd0, e0_p});
    check_eq("par_err1", {31'd0, p1}, {31'd0, e1_p});
  endtask

  // Count busy cycles until ready, optionally poking the ports while busy.
  task automatic wait_clear(input bit poke, output int n);
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      n++;
      if (poke) drive(1'b1, 4'd5, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'd5);
      else idle();
      tick();
    end
    idle();
  endtask

  initial begin
    int n;
    logic we, re;
    logic [AW-1:0] wa, ra;

    clear_left = 0;
    idle();
    reset = 1'b1;
    tick();
    check_eq("reset_busy", {31'd0, busy0}, 32'd1);
    reset = 1'b0;
    wait_clear(1'b0, n);
    check_eq("clear_len", n, 16);

    // Cleared word reads back zero.
    drive(1'b0, '0, '0, '0, 1'b1, 4'd5); tick();
    check_eq("rd5_zero", d0, 32'h0);
    idle(); tick(); tick();

    // Byte-enable merge.
    drive(1'b1, 4'd3, 4'b1111, 32'hAABB_CCDD, 1'b0, '0); tick();
    drive(1'b1, 4'd3, 4'b0101, 32'h1122_3344, 1'b0, '0); tick();
    drive(1'b0, '0, '0, '0, 1'b1, 4'd3); tick();
    check_eq("be_merge0", d0, 32'hAA22_CC44);
    idle(); tick();
    check_eq("be_merge1", d1, 32'hAA22_CC44);
    tick();

    // Back-to-back reads.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(i), 4'hF, 32'(i + 1), 1'b0, '0); tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, AW'(i)); tick();
    end
    idle(); tick(); tick(); tick();

    // Read-during-write, same address.
    drive(1'b1, 4'd7, 4'hF, 32'hCAFE_F00D, 1'b0, '0); tick();
    drive(1'b1, 4'd7, 4'hF, 32'h1234_5678, 1'b1, 4'd7); tick();
    check_eq("rdw_old", d0, 32'hCAFE_F00D);
    idle(); tick();
    check_eq("rdw_new", d1, 32'h1234_5678);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd7); tick();
    check_eq("rdw_after0", d0, 32'h1234_5678);
    idle(); tick();
    check_eq("rdw_after1", d1, 32'h1234_5678);
    tick();

    // Reset in the middle of the clear, ports pulsed while busy.
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    wait_clear(1'b1, n);
    check_eq("reclear_len", n, 16);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd5); tick();
    check_eq("busy_no_write", d0, 32'h0);
    idle(); tick(); tick();

    // Random traffic with frequent address collisions.
    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      drive(we, wa, NBL'($urandom), $urandom, re, ra);
      tick();
    end
    idle(); tick(); tick();

`ifdef RAM_SDP_BE_PARITY_EN
    // Corrupt one stored bit in lane 1 of word 2 in both instances.
    drive(1'b1, 4'd2, 4'hF, 32'h0, 1'b0, '0); tick();
    idle(); tick();
    dut0.mem_q[2][8] = ~dut0.mem_q[2][8];
    dut1.mem_q[2][8] = ~dut1.mem_q[2][8];
    m_mem[2] = m_mem[2] ^ 32'h0000_0100;
    m_bad[2] = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b1, 4'd2); tick();
    check_eq("par_err_flip0", {31'd0, p0}, 32'd1);
    idle(); tick();
    check_eq("par_err_flip1", {31'd0, p1}, 32'd1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
